// File: rtl/fetch_cycle.sv
// ---------------------------------------------------------------------------
// fetch_cycle
//
// Instruction fetch stage with an IF/ID pipeline register. It keeps the next
// fetch PC (PCF), issues one request at a time to a variable-latency
// instruction memory, and handles decode stalls, hazard flushes and redirects
// from execute.
//
// Control is a three-state FSM:
//   FETCH - request IMemAddr = PCF and accept the response when it comes
//   HOLD  - decode stalled while a response arrived; the instruction waits
//           in a one-entry skid buffer and no new request is made
//   DROP  - a redirect arrived while a request was still outstanding; the
//           old address is held until the memory answers, then the answer
//           is thrown away
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous reset, active low
//   StallD     in   1  decode cannot accept a new instruction
//   FlushD     in   1  kill the IF/ID contents
//   PCSrcE     in   1  taken branch/jump redirect from execute
//   PCTargetE  in   9  redirect target (word address)
//   IMemReq    out  1  instruction memory request
//   IMemAddr   out  9  instruction word address, stable until IMemAck
//   IMemAck    in   1  memory response, IMemRdata valid in the same cycle
//   IMemRdata  in  33  fetched instruction
//   InstrD     out 33  IF/ID instruction
//   PCD        out  9  IF/ID PC
//   PCPlus4D   out  9  IF/ID PC + 1 (word addressing, wraps at 512)
//   ValidD     out  1  IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module fetch_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [8:0]  PCTargetE,
  output logic        IMemReq,
  output logic [8:0]  IMemAddr,
  input  logic        IMemAck,
  input  logic [32:0] IMemRdata,
  output logic [32:0] InstrD,
  output logic [8:0]  PCD,
  output logic [8:0]  PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [8:0]  r_pcF;
  logic [8:0]  r_dropAddr;
  logic [32:0] r_skidInstr;
  logic [8:0]  r_skidPc;

  logic [32:0] r_instrD;
  logic [8:0]  r_pcD;
  logic [8:0]  r_pcPlus4D;
  logic        r_validD;

  logic [8:0]  w_pcPlus1F;
  logic [8:0]  w_pcNext;
  logic        w_haveInstr;
  logic [32:0] w_instr;
  logic [8:0]  w_instrPc;
  logic        w_skidLoad;
  logic        w_dropLoad;
  logic        w_flushD;

  assign w_pcPlus1F = r_pcF + 9'd1;

  // A redirect always invalidates whatever sits in IF/ID or would enter it.
  assign w_flushD = FlushD | PCSrcE;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FETCH: begin
        if (IMemAck) begin
          if (!PCSrcE && StallD) begin
            w_nextState = HOLD;
          end
        end else if (PCSrcE) begin
          w_nextState = DROP;
        end
      end
      HOLD: begin
        if (PCSrcE || !StallD) begin
          w_nextState = FETCH;
        end
      end
      DROP: begin
        if (IMemAck) begin
          w_nextState = FETCH;
        end
      end
      default: w_nextState = FETCH;
    endcase
  end

  // Output / datapath control decode. w_haveInstr marks an instruction that
  // is ready to enter IF/ID this cycle, either straight from memory or from
  // the skid buffer; whether it actually enters is decided by the IF/ID
  // priority in the register process below.
  always_comb begin
    IMemReq     = 1'b0;
    IMemAddr    = r_pcF;
    w_haveInstr = 1'b0;
    w_instr     = IMemRdata;
    w_instrPc   = r_pcF;
    w_pcNext    = r_pcF;
    w_skidLoad  = 1'b0;
    w_dropLoad  = 1'b0;
    case (r_state)
      FETCH: begin
        IMemReq = 1'b1;
        if (IMemAck) begin
          if (PCSrcE) begin
            w_pcNext = PCTargetE;
          end else begin
            w_pcNext = w_pcPlus1F;
            if (StallD) begin
              w_skidLoad = 1'b1;
            end else begin
              w_haveInstr = 1'b1;
            end
          end
        end else if (PCSrcE) begin
          w_dropLoad = 1'b1;
          w_pcNext   = PCTargetE;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          w_pcNext = PCTargetE;
        end else if (!StallD) begin
          w_haveInstr = 1'b1;
          w_instr     = r_skidInstr;
          w_instrPc   = r_skidPc;
        end
      end
      DROP: begin
        IMemReq  = 1'b1;
        IMemAddr = r_dropAddr;
        if (PCSrcE) begin
          w_pcNext = PCTargetE;
        end
      end
      default: begin
        IMemReq = 1'b0;
      end
    endcase
    // Dropping the request during reset is how an outstanding access is
    // cancelled, so the request and address are forced low here.
    if (!rst) begin
      IMemReq  = 1'b0;
      IMemAddr = 9'h000;
    end
  end

  // Fetch PC, drop address and skid buffer. A flush does not block the skid
  // capture: the stalled instruction is younger than the one being killed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pcF       <= 9'h000;
      r_dropAddr  <= 9'h000;
      r_skidInstr <= 33'h0;
      r_skidPc    <= 9'h000;
    end else begin
      r_pcF <= w_pcNext;
      if (w_dropLoad) begin
        r_dropAddr <= r_pcF;
      end
      if (w_skidLoad) begin
        r_skidInstr <= IMemRdata;
        r_skidPc    <= r_pcF;
      end
    end
  end

  // IF/ID register: flush beats stall, stall beats a new instruction, and
  // with nothing to load a bubble is inserted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_instrD   <= 33'h0;
      r_pcD      <= 9'h000;
      r_pcPlus4D <= 9'h000;
      r_validD   <= 1'b0;
    end else if (w_flushD) begin
      r_instrD   <= 33'h0;
      r_pcD      <= 9'h000;
      r_pcPlus4D <= 9'h000;
      r_validD   <= 1'b0;
    end else if (StallD) begin
      r_instrD   <= r_instrD;
      r_pcD      <= r_pcD;
      r_pcPlus4D <= r_pcPlus4D;
      r_validD   <= r_validD;
    end else if (w_haveInstr) begin
      r_instrD   <= w_instr;
      r_pcD      <= w_instrPc;
      r_pcPlus4D <= w_instrPc + 9'd1;
      r_validD   <= 1'b1;
    end else begin
      r_instrD   <= 33'h0;
      r_pcD      <= 9'h000;
      r_pcPlus4D <= 9'h000;
      r_validD   <= 1'b0;
    end
  end

  assign InstrD   = r_instrD;
  assign PCD      = r_pcD;
  assign PCPlus4D = r_pcPlus4D;
  assign ValidD   = r_validD;

endmodule

// File: tb/tb_fetch_cycle.sv
// ---------------------------------------------------------------------------
// tb_fetch_cycle
//
// Directed bench for fetch_cycle. A small instruction memory model answers
// each request after memLatency cycles (0 = same-cycle ack) and returns data
// tagged with the requested address, so the IF/ID contents can be checked
// against hand-computed PCs.
// ---------------------------------------------------------------------------
module tb_fetch_cycle;

  logic        clk;
  logic        rst;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [8:0]  PCTargetE;
  logic        IMemReq;
  logic [8:0]  IMemAddr;
  logic        IMemAck;
  logic [32:0] IMemRdata;
  logic [32:0] InstrD;
  logic [8:0]  PCD;
  logic [8:0]  PCPlus4D;
  logic        ValidD;

  int checks = 0;
  int passed = 0;
  int memLatency = 0;
  int memCount = 0;

  localparam logic [23:0] TAG = 24'h5A5A5A;

  fetch_cycle dut (
    .clk       (clk),
    .rst       (rst),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .IMemReq   (IMemReq),
    .IMemAddr  (IMemAddr),
    .IMemAck   (IMemAck),
    .IMemRdata (IMemRdata),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: counts cycles a request has been pending, acks once the
  // count reaches memLatency, and restarts on ack or when the request drops.
  always @(posedge clk) begin
    if (!IMemReq || IMemAck) begin
      memCount <= 0;
    end else begin
      memCount <= memCount + 1;
    end
  end

  assign IMemAck   = IMemReq && (memCount >= memLatency);
  assign IMemRdata = {TAG, IMemAddr};

  // Advance one clock and settle just after the edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 9'h000;
    step();
    step();
    checks++; if (IMemReq !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", IMemReq); else passed++;
    checks++; if (ValidD !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", ValidD); else passed++;
    checks++; if (PCD !== 9'h000) $display("[TB] FAIL reset_pcd: got %h expected 000", PCD); else passed++;
    checks++; if (PCPlus4D !== 9'h000) $display("[TB] FAIL reset_pcplus: got %h expected 000", PCPlus4D); else passed++;
    checks++; if (InstrD !== 33'h0) $display("[TB] FAIL reset_instr: got %h expected 0", InstrD); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (IMemReq !== 1'b1) $display("[TB] FAIL first_req: got %b expected 1", IMemReq); else passed++;
    checks++; if (IMemAddr !== 9'h000) $display("[TB] FAIL first_addr: got %h expected 000", IMemAddr); else passed++;
  endtask

  task automatic test_stream;
    logic [8:0] expPc;
    for (int i = 0; i < 4; i++) begin
      step();
      expPc = 9'(i);
      checks++; if (PCD !== expPc) $display("[TB] FAIL stream_pcd[%0d]: got %h expected %h", i, PCD, expPc); else passed++;
      checks++; if (PCPlus4D !== expPc + 9'd1) $display("[TB] FAIL stream_pcplus[%0d]: got %h expected %h", i, PCPlus4D, expPc + 9'd1); else passed++;
      checks++; if (ValidD !== 1'b1) $display("[TB] FAIL stream_valid[%0d]: got %b expected 1", i, ValidD); else passed++;
      checks++; if (InstrD !== {TAG, expPc}) $display("[TB] FAIL stream_instr[%0d]: got %h expected %h", i, InstrD, {TAG, expPc}); else passed++;
    end
  endtask

  task automatic test_stall;
    step();
    checks++; if (PCD !== 9'h004) $display("[TB] FAIL stall_pre_pcd: got %h expected 004", PCD); else passed++;
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (PCD !== 9'h004) $display("[TB] FAIL stall_hold_pcd[%0d]: got %h expected 004", i, PCD); else passed++;
      checks++; if (IMemReq !== 1'b0) $display("[TB] FAIL stall_req[%0d]: got %b expected 0", i, IMemReq); else passed++;
    end
    StallD = 1'b0;
    step();
    checks++; if (PCD !== 9'h005) $display("[TB] FAIL stall_release_pcd: got %h expected 005", PCD); else passed++;
    checks++; if (PCPlus4D !== 9'h006) $display("[TB] FAIL stall_release_pcplus: got %h expected 006", PCPlus4D); else passed++;
    checks++; if (InstrD !== {TAG, 9'h005}) $display("[TB] FAIL stall_release_instr: got %h expected %h", InstrD, {TAG, 9'h005}); else passed++;
    checks++; if (IMemAddr !== 9'h006) $display("[TB] FAIL stall_next_addr: got %h expected 006", IMemAddr); else passed++;
    step();
    checks++; if (PCD !== 9'h006) $display("[TB] FAIL stall_after_pcd: got %h expected 006", PCD); else passed++;
  endtask

  task automatic test_redirect_on_ack;
    PCSrcE = 1'b1; PCTargetE = 9'h040;
    step();
    PCSrcE = 1'b0;
    checks++; if (ValidD !== 1'b0) $display("[TB] FAIL br_ack_valid: got %b expected 0", ValidD); else passed++;
    checks++; if (PCD !== 9'h000) $display("[TB] FAIL br_ack_pcd: got %h expected 000", PCD); else passed++;
    checks++; if (IMemAddr !== 9'h040) $display("[TB] FAIL br_ack_addr: got %h expected 040", IMemAddr); else passed++;
    step();
    checks++; if (PCD !== 9'h040 || ValidD !== 1'b1) $display("[TB] FAIL br_ack_target_pcd: got %h/%b expected 040/1", PCD, ValidD); else passed++;
  endtask

  task automatic test_redirect_latency;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    memLatency = 3;
    step();
    checks++; if (IMemAddr !== 9'h002) $display("[TB] FAIL lat_addr0: got %h expected 002", IMemAddr); else passed++;
    checks++; if (ValidD !== 1'b0) $display("[TB] FAIL lat_valid0: got %b expected 0", ValidD); else passed++;
    PCSrcE = 1'b1; PCTargetE = 9'h040;
    step();
    PCSrcE = 1'b0;
    checks++; if (IMemAddr !== 9'h002 || IMemReq !== 1'b1) $display("[TB] FAIL lat_addr1: got %h/%b expected 002/1", IMemAddr, IMemReq); else passed++;
    checks++; if (ValidD !== 1'b0) $display("[TB] FAIL lat_valid1: got %b expected 0", ValidD); else passed++;
    step();
    checks++; if (IMemAddr !== 9'h002) $display("[TB] FAIL lat_addr2: got %h expected 002", IMemAddr); else passed++;
    checks++; if (ValidD !== 1'b0) $display("[TB] FAIL lat_valid2: got %b expected 0", ValidD); else passed++;
    step();
    checks++; if (IMemAddr !== 9'h040) $display("[TB] FAIL lat_target_addr: got %h expected 040", IMemAddr); else passed++;
    checks++; if (ValidD !== 1'b0) $display("[TB] FAIL lat_valid3: got %b expected 0", ValidD); else passed++;
    memLatency = 0;
    step();
    checks++; if (PCD !== 9'h040 || ValidD !== 1'b1) $display("[TB] FAIL lat_target_pcd: got %h/%b expected 040/1", PCD, ValidD); else passed++;
  endtask

  task automatic test_wrap;
    PCSrcE = 1'b1; PCTargetE = 9'h1FF;
    step();
    PCSrcE = 1'b0;
    checks++; if (IMemAddr !== 9'h1FF) $display("[TB] FAIL wrap_addr: got %h expected 1ff", IMemAddr); else passed++;
    step();
    checks++; if (PCD !== 9'h1FF) $display("[TB] FAIL wrap_pcd: got %h expected 1ff", PCD); else passed++;
    checks++; if (PCPlus4D !== 9'h000) $display("[TB] FAIL wrap_pcplus: got %h expected 000", PCPlus4D); else passed++;
    checks++; if (IMemAddr !== 9'h000) $display("[TB] FAIL wrap_next_addr: got %h expected 000", IMemAddr); else passed++;
    step();
    checks++; if (PCD !== 9'h000 || ValidD !== 1'b1) $display("[TB] FAIL wrap_after_pcd: got %h/%b expected 000/1", PCD, ValidD); else passed++;
  endtask

  task automatic test_reset_in_drop;
    memLatency = 3;
    PCSrcE = 1'b1; PCTargetE = 9'h080;
    step();
    PCSrcE = 1'b0;
    checks++; if (IMemAddr !== 9'h001) $display("[TB] FAIL drop_addr: got %h expected 001", IMemAddr); else passed++;
    rst = 1'b0;
    step();
    checks++; if (IMemReq !== 1'b0) $display("[TB] FAIL drop_rst_req: got %b expected 0", IMemReq); else passed++;
    checks++; if (IMemAddr !== 9'h000) $display("[TB] FAIL drop_rst_addr: got %h expected 000", IMemAddr); else passed++;
    checks++; if (ValidD !== 1'b0 || PCD !== 9'h000 || PCPlus4D !== 9'h000 || InstrD !== 33'h0)
      $display("[TB] FAIL drop_rst_ifid: got %b/%h/%h/%h expected all zero", ValidD, PCD, PCPlus4D, InstrD); else passed++;
    rst = 1'b1;
    memLatency = 0;
    #1;
    checks++; if (IMemAddr !== 9'h000 || IMemReq !== 1'b1) $display("[TB] FAIL drop_release_addr: got %h/%b expected 000/1", IMemAddr, IMemReq); else passed++;
    step();
    checks++; if (PCD !== 9'h000 || ValidD !== 1'b1) $display("[TB] FAIL drop_release_pcd: got %h/%b expected 000/1", PCD, ValidD); else passed++;
  endtask

  task automatic test_reset_in_hold;
    StallD = 1'b1;
    step();
    checks++; if (IMemReq !== 1'b0) $display("[TB] FAIL hold_req: got %b expected 0", IMemReq); else passed++;
    rst = 1'b0; StallD = 1'b0;
    step();
    checks++; if (IMemReq !== 1'b0) $display("[TB] FAIL hold_rst_req: got %b expected 0", IMemReq); else passed++;
    checks++; if (ValidD !== 1'b0 || PCD !== 9'h000 || PCPlus4D !== 9'h000 || InstrD !== 33'h0)
      $display("[TB] FAIL hold_rst_ifid: got %b/%h/%h/%h expected all zero", ValidD, PCD, PCPlus4D, InstrD); else passed++;
    rst = 1'b1;
    step();
    checks++; if (PCD !== 9'h000 || ValidD !== 1'b1) $display("[TB] FAIL hold_release_pcd: got %h/%b expected 000/1", PCD, ValidD); else passed++;
  endtask

  task automatic test_flush_skid;
    FlushD = 1'b1; StallD = 1'b1;
    step();
    FlushD = 1'b0;
    checks++; if (ValidD !== 1'b0 || PCD !== 9'h000) $display("[TB] FAIL flush_ifid: got %b/%h expected 0/000", ValidD, PCD); else passed++;
    checks++; if (IMemReq !== 1'b0) $display("[TB] FAIL flush_hold_req: got %b expected 0", IMemReq); else passed++;
    StallD = 1'b0;
    step();
    checks++; if (PCD !== 9'h001 || ValidD !== 1'b1) $display("[TB] FAIL flush_skid_pcd: got %h/%b expected 001/1", PCD, ValidD); else passed++;
    step();
    checks++; if (PCD !== 9'h002) $display("[TB] FAIL flush_next_pcd: got %h expected 002", PCD); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_on_ack();
    test_redirect_latency();
    test_wrap();
    test_reset_in_drop();
    test_reset_in_hold();
    test_flush_skid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, %0d/%0d checks passed so far", passed, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
